// File: rtl/ex_alu_mc.sv
// ex_alu_mc: registered execute ALU with iterative multiply and optional
// unsigned divide/remainder, valid/ready handshakes and flush.
// Optional divider: define EX_ALU_DIV_EN to build divu/remu hardware;
// otherwise codes 11010/11011 are single-cycle ops returning zero.

module ex_alu_mc #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] reg1,
    input  logic [XLEN-1:0] reg2,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic            alu_src1,
    input  logic            alu_src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_out,
    output logic [4:0]      op_out,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ITER = 1'b1;

    localparam logic [4:0] OP_SUB = 5'b01110;
    localparam logic [4:0] OP_SLL = 5'b01000;
    localparam logic [4:0] OP_SRL = 5'b01001;
    localparam logic [4:0] OP_XOR = 5'b00110;
    localparam logic [4:0] OP_OR  = 5'b00101;
    localparam logic [4:0] OP_AND = 5'b00100;

    logic [0:0]      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opnd;
    logic [4:0]      cur_op;

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] sc_res;
    logic            multi;
    logic            accept;
    logic [XLEN-1:0] hi_n;
    logic [XLEN-1:0] lo_n;
    logic [XLEN:0]   mul_sum;
`ifdef EX_ALU_DIV_EN
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;
`endif

    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    // Operand selection: PC/reg1 and Imm/reg2
    always_comb begin
        op1 = alu_src1 ? pc  : reg1;
        op2 = alu_src2 ? imm : reg2;
    end

    // Decode which codes run through the iterative engine
    always_comb begin
`ifdef EX_ALU_DIV_EN
        multi = (alu_op[4:2] == 3'b110);
`else
        multi = (alu_op[4:1] == 4'b1100);
`endif
    end

    // Single-cycle result; undefined codes yield zero
    always_comb begin
        sc_res = '0;
        case (alu_op)
            5'b10001, 5'b10010, 5'b10100,
            5'b10101, 5'b01100, 5'b01101: sc_res = op1 + op2;
            OP_SUB:  sc_res = op1 - op2;
            OP_SLL:  sc_res = op1 << op2[SHW-1:0];
            OP_SRL:  sc_res = op1 >> op2[SHW-1:0];
            OP_XOR:  sc_res = op1 ^ op2;
            OP_OR:   sc_res = op1 | op2;
            OP_AND:  sc_res = op1 & op2;
            default: sc_res = '0;
        endcase
    end

    // One iteration step: {hi,lo} is the shared product / remainder:quotient pair
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        hi_n    = mul_sum[XLEN:1];
        lo_n    = {mul_sum[0], lo[XLEN-1:1]};
`ifdef EX_ALU_DIV_EN
        // Restoring divide; a zero divisor always "fits", giving all-ones
        // quotient and the dividend as remainder without special-casing.
        div_shift = {hi, lo[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift[XLEN-1:0] - opnd;
        if (cur_op[1]) begin
            hi_n = div_ge ? div_diff : div_shift[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], div_ge};
        end
`endif
    end

    // Control FSM, iteration registers and output holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            opnd      <= '0;
            cur_op    <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            alu_out   <= '0;
            op_out    <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (multi) begin
                    state  <= S_ITER;
                    busy   <= 1'b1;
                    cnt    <= CW'(XLEN - 1);
                    hi     <= '0;
                    lo     <= op1;
                    opnd   <= op2;
                    cur_op <= alu_op;
                end else begin
                    out_valid <= 1'b1;
                    alu_out   <= sc_res;
                    op_out    <= alu_op;
                end
            end
            if (state == S_ITER) begin
                hi  <= hi_n;
                lo  <= lo_n;
                cnt <= cnt - 1'b1;
                if (cnt == '0) begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b1;
                    // odd codes (mulhu/remu) take the high half
                    alu_out   <= cur_op[0] ? hi_n : lo_n;
                    op_out    <= cur_op;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_alu_mc.sv
// tb_ex_alu_mc: directed self-checking bench for ex_alu_mc.
// Divider vectors follow EX_ALU_DIV_EN.

module tb_ex_alu_mc;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      alu_op;
    logic [XLEN-1:0] reg1;
    logic [XLEN-1:0] reg2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            alu_src1;
    logic            alu_src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_out;
    logic [4:0]      op_out;
    logic            busy;

    int checks = 0;
    int errors = 0;

    ex_alu_mc #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .reg1      (reg1),
        .reg2      (reg2),
        .imm       (imm),
        .pc        (pc),
        .alu_src1  (alu_src1),
        .alu_src2  (alu_src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .op_out    (op_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Single-cycle op: accept on one edge, result visible right after it
    task automatic issue_sc(input string tag, input logic [4:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] im, input logic [31:0] p,
                            input logic s1, input logic s2,
                            input logic [31:0] exp);
        out_ready = 1'b1;
        alu_op = op; reg1 = a; reg2 = b; imm = im; pc = p;
        alu_src1 = s1; alu_src2 = s2; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        chk1 ({tag, "_valid"}, out_valid, 1'b1);
        chk32({tag, "_out"}, alu_out, exp);
        chk32({tag, "_op"}, {27'b0, op_out}, {27'b0, op});
    endtask

    // Multi-cycle op: out_valid must appear exactly XLEN edges after accept
    task automatic run_multi(input string tag, input logic [4:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp);
        logic ok;
        out_ready = 1'b1;
        chk1({tag, "_in_ready"}, in_ready, 1'b1);
        alu_op = op; reg1 = a; reg2 = b; alu_src1 = 1'b0; alu_src2 = 1'b0;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        reg1 = ~a;
        reg2 = b + 32'd1;
        ok = 1'b1;
        for (int i = 0; i < XLEN; i++) begin
            if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
            tick;
        end
        chk1 ({tag, "_iter"}, ok, 1'b1);
        chk1 ({tag, "_valid"}, out_valid, 1'b1);
        chk1 ({tag, "_busy"}, busy, 1'b0);
        chk32({tag, "_out"}, alu_out, exp);
        chk32({tag, "_op"}, {27'b0, op_out}, {27'b0, op});
    endtask

    task automatic no_result(input string tag, input int cycles);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            tick;
            if (out_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        chk1(tag, ok, 1'b1);
    endtask

    initial begin
        logic [4:0] long_op;
        logic       ok;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; alu_op = '0;
        reg1 = '0; reg2 = '0; imm = '0; pc = '0;
        alu_src1 = 1'b0; alu_src2 = 1'b0; out_ready = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        chk1 ("rst_valid", out_valid, 1'b0);
        chk1 ("rst_busy", busy, 1'b0);
        chk32("rst_out", alu_out, 32'h0);
        chk32("rst_op", {27'b0, op_out}, 32'h0);
        chk1 ("rst_in_ready", in_ready, 1'b1);

        // 1: add with immediate
        issue_sc("add_imm", 5'b01100, 32'd5, 32'd99, 32'd7, 32'd0, 1'b0, 1'b1, 32'd12);

        // 2: back-to-back sub then sll, in_valid held
        alu_op = 5'b01110; reg1 = 32'd0; reg2 = 32'd1; alu_src1 = 1'b0; alu_src2 = 1'b0;
        in_valid = 1'b1;
        tick;
        chk1 ("b2b_sub_valid", out_valid, 1'b1);
        chk32("b2b_sub_out", alu_out, 32'hFFFF_FFFF);
        alu_op = 5'b01000; reg1 = 32'd1; reg2 = 32'h23;
        tick;
        in_valid = 1'b0;
        chk1 ("b2b_sll_valid", out_valid, 1'b1);
        chk32("b2b_sll_out", alu_out, 32'h8);
        chk32("b2b_sll_op", {27'b0, op_out}, 32'h08);
        tick;
        chk1("b2b_drain", out_valid, 1'b0);

        // Remaining single-cycle codes and boundaries
        issue_sc("add_pc", 5'b10001, 32'd0, 32'd0, 32'h20, 32'h100, 1'b1, 1'b1, 32'h120);
        issue_sc("add_wrap", 5'b10101, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 32'h1);
        issue_sc("srl_mask", 5'b01001, 32'h8000_0000, 32'h3F, 32'd0, 32'd0, 1'b0, 1'b0, 32'h1);
        issue_sc("sll_by32", 5'b01000, 32'h1, 32'h20, 32'd0, 32'd0, 1'b0, 1'b0, 32'h1);
        issue_sc("xor", 5'b00110, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFF00);
        issue_sc("or", 5'b00101, 32'hF0, 32'h0F, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFF);
        issue_sc("and", 5'b00100, 32'hF0, 32'h3C, 32'd0, 32'd0, 1'b0, 1'b0, 32'h30);
        issue_sc("undef", 5'b00000, 32'd5, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0);

        // 3: multiply family
        run_multi("mul", 5'b11000, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE);
        run_multi("mulhu", 5'b11001, 32'hFFFF_FFFF, 32'h2, 32'h1);
        run_multi("mul_small", 5'b11000, 32'd7, 32'd6, 32'd42);
        run_multi("mulhu_max", 5'b11001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_multi("mul_max", 5'b11000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);

        // 4: divide / remainder
`ifdef EX_ALU_DIV_EN
        run_multi("divu", 5'b11010, 32'd100, 32'd7, 32'd14);
        run_multi("remu", 5'b11011, 32'd100, 32'd7, 32'd2);
        run_multi("divu_z", 5'b11010, 32'd9, 32'd0, 32'hFFFF_FFFF);
        run_multi("remu_z", 5'b11011, 32'd9, 32'd0, 32'd9);
        run_multi("divu_1", 5'b11010, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
        run_multi("remu_16", 5'b11011, 32'hFFFF_FFFF, 32'h10, 32'hF);
        long_op = 5'b11010;
`else
        issue_sc("divu_off", 5'b11010, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0);
        issue_sc("remu_off", 5'b11011, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0);
        long_op = 5'b11000;
`endif

        // 5: output hold under backpressure
        out_ready = 1'b1;
        tick;
        chk1("hold_pre", out_valid, 1'b0);
        out_ready = 1'b0;
        alu_op = 5'b00110; reg1 = 32'hF0F0; reg2 = 32'h0FF0; alu_src1 = 1'b0; alu_src2 = 1'b0;
        in_valid = 1'b1;
        tick;
        alu_op = 5'b00100; reg1 = 32'h1234; reg2 = 32'hFFFF;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_out !== 32'hFF00
                || op_out !== 5'b00110) ok = 1'b0;
            tick;
        end
        chk1 ("hold_stable", ok, 1'b1);
        chk32("hold_out", alu_out, 32'hFF00);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        chk1("hold_release", out_valid, 1'b0);

        // 6a: flush at cycle 10 of a multiply, add offered same edge is ignored
        alu_op = 5'b11000; reg1 = 32'd3; reg2 = 32'd5; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (9) tick;
        flush = 1'b1;
        chk1("flush_in_ready", in_ready, 1'b0);
        alu_op = 5'b01100; reg1 = 32'd1; reg2 = 32'd1; in_valid = 1'b1;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        chk1("flush_busy", busy, 1'b0);
        chk1("flush_valid", out_valid, 1'b0);
        no_result("flush_quiet", 40);
        issue_sc("post_flush_add", 5'b01100, 32'd2, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 32'd5);

        // 6b: flush on the completion edge wins over completion
        tick;
        alu_op = 5'b11000; reg1 = 32'd3; reg2 = 32'd5; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (31) tick;
        chk1("flush_last_busy_pre", busy, 1'b1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk1("flush_last_valid", out_valid, 1'b0);
        no_result("flush_last_quiet", 5);

        // 6c: flush drops a held result even with out_ready low
        issue_sc("flush_hold_add", 5'b01101, 32'd10, 32'd20, 32'd0, 32'd0, 1'b0, 1'b0, 32'd30);
        out_ready = 1'b0;
        tick;
        chk1("flush_hold_pre", out_valid, 1'b1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        out_ready = 1'b1;
        chk1("flush_hold_valid", out_valid, 1'b0);

        // 6d: reset at cycle 10 of a long op
        alu_op = long_op; reg1 = 32'd100; reg2 = 32'd7; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (9) tick;
        rst = 1'b1;
        flush = 1'b1;
        tick;
        rst = 1'b0;
        flush = 1'b0;
        chk1 ("rst_mid_busy", busy, 1'b0);
        chk1 ("rst_mid_valid", out_valid, 1'b0);
        chk32("rst_mid_out", alu_out, 32'h0);
        chk32("rst_mid_op", {27'b0, op_out}, 32'h0);
        no_result("rst_mid_quiet", 40);
        issue_sc("post_rst_add", 5'b10010, 32'd40, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 32'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
